output_control: RTL and testbench
=================================

Name: output_control

Overview:
- Drain side of the systolic core: inverse of the serial-in load path.
- Captures the N*N result words from the array in one cycle, then serialises them out on a single pin, LSB first, word by word.
- Lets the tile return results over the same narrow bit-serial pin budget used for operand loading.
- Sits between the PE array result bus and the chip output pins; controlled by a one-cycle capture strobe and a bit-level shift enable.

Parameters:
- N, 2, array dimension; N*N result words are drained (N >= 2).
- R_W, 16, result word width in bits (power of two, >= 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- in_z_flat  input  N*N*R_W  flat result bus; word k at bits [(k+1)*R_W-1 -: R_W], k = row*N+col.
- capture  input  1  request to latch in_z_flat and start draining; honoured only in IDLE.
- shift_en  input  1  bit-level advance; low stalls the serial stream.
- data_out  output  1  serial result bit.
- out_valid  output  1  data_out carries a new bit this cycle.
- word_last  output  1  current data_out bit is the last bit of a word.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; data_out, out_valid, word_last, done = 0.
  - Capture buffer cleared; bit_cnt and word_cnt = 0.
  - Reset mid-drain aborts immediately; no done pulse.
- State machine: IDLE, SHIFT, DONE (2-bit register).
- IDLE:
  - busy=0.
  - capture=1 at edge k: all N*N words copied to an internal buffer at edge k; state -> SHIFT; counters cleared.
- SHIFT:
  - At each edge with shift_en=1:
    - data_out <= buffer[word_cnt][bit_cnt].
    - out_valid <= 1.
    - word_last <= (bit_cnt == R_W-1).
    - bit_cnt increments and wraps at R_W-1 to 0; word_cnt increments on that wrap.
  - At each edge with shift_en=0: out_valid <= 0, word_last <= 0; data_out holds its value; counters hold.
  - After the bit at word_cnt == N*N-1 and bit_cnt == R_W-1 is issued: state -> DONE.
- DONE:
  - done=1 for exactly one cycle; out_valid <= 0.
  - state -> IDLE on the next edge.
- Latency: capture sampled at edge k; with shift_en held high, the first bit is valid after edge k+1.
- Stream length: N*N*R_W valid bits; with no stalls, out_valid is high for exactly that many consecutive cycles.
- capture while busy=1 is ignored; the buffer is not overwritten mid-drain.
- capture and shift_en both high in IDLE: only the capture is acted on; no bit is shifted that cycle.
- in_z_flat is sampled only at the capture edge; later changes have no effect.
- done and busy are registered: busy stays 1 through DONE and falls on the cycle after done.

Optional Feature:
- Macro: OUTPUT_PARITY_EN.
- Defined:
  - After the R_W data bits of each word, one extra bit is issued: even parity (XOR of the word's R_W bits).
  - word_last asserts on the parity bit, not on data bit R_W-1.
  - Stream length becomes N*N*(R_W+1); bit_cnt wraps at R_W.
- Undefined: no parity bit; word_last on data bit R_W-1; stream length N*N*R_W.

Test Plan:
- Reset then idle, shift_en toggling, no capture -> out_valid, done, busy, data_out stay 0.
- N=2, R_W=16, in_z_flat words {0x0001, 0x8000, 0xA5A5, 0xFFFF}, capture pulse, shift_en=1 -> 64 consecutive valid bits; first bit 1, bit 31 = 1, bits 48..63 all 1; word_last at bits 15/31/47/63; done pulses 1 cycle after bit 63.
- Same stimulus with shift_en low for 3 cycles after bit 20 -> out_valid=0 for those 3 cycles, data_out held, stream resumes at bit 21; total valid count still 64.
- capture re-asserted mid-drain with in_z_flat changed to all zeros -> ignored; original words still emitted.
- rst=0 asserted at bit 30 -> next cycle busy=0, out_valid=0, no done; a fresh capture restarts from word 0 bit 0.
- OUTPUT_PARITY_EN defined, words {0x0003, 0x0001, 0, 0} -> 68 bits; parity bits 0, 1, 0, 0; word_last on bits 16/33/50/67.

Source files
------------

// File: rtl/output_control.sv
// Purpose: drain side of the systolic core. Latches the N*N result words in one
//          cycle, then streams them out bit-serially, LSB first, word 0 first.
// Latency: capture at edge k; with shift_en high, the first bit is valid after edge k+1.
// Backpressure: shift_en low stalls the stream (out_valid drops, data_out and counters hold).
// Optional feature: define OUTPUT_PARITY_EN to append an even-parity bit after each word.
// Ports:
//   clk, rst (sync, active-low)  | in_z_flat : word k at [(k+1)*R_W-1 -: R_W], k=row*N+col
//   capture   : latch + start (IDLE only) | shift_en : bit-level advance
//   data_out / out_valid / word_last : serial bit, its qualifier, end-of-word marker
//   busy      : drain in progress (through the done cycle) | done : one-cycle end pulse
module output_control #(
    parameter int N   = 2,
    parameter int R_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*N*R_W-1:0] in_z_flat,
    input  logic               capture,
    input  logic               shift_en,
    output logic               data_out,
    output logic               out_valid,
    output logic               word_last,
    output logic               busy,
    output logic               done
);

    localparam int WORDS = N * N;
`ifdef OUTPUT_PARITY_EN
    localparam int BPW = R_W + 1;   // data bits plus trailing parity bit
`else
    localparam int BPW = R_W;
`endif
    localparam int CW = $clog2(R_W + 1);
    localparam int IW = $clog2(R_W);
    localparam int WW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(BPW - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
`ifdef OUTPUT_PARITY_EN
    localparam logic [CW-1:0] PAR_BIT   = CW'(R_W);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [R_W-1:0] buf_q [WORDS];
    logic [CW-1:0]  bit_cnt;
    logic [WW-1:0]  word_cnt;
    logic [R_W-1:0] cur_word;
    logic           cur_bit;

    // Bit to be issued at the next shifting edge.
    always_comb begin
        cur_word = buf_q[word_cnt];
        cur_bit  = cur_word[bit_cnt[IW-1:0]];
`ifdef OUTPUT_PARITY_EN
        if (bit_cnt == PAR_BIT) begin
            cur_bit = ^cur_word;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            word_last <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            for (int i = 0; i < WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    word_last <= 1'b0;
                    done      <= 1'b0;
                    // busy is held through the done pulse and released one cycle later,
                    // so a capture arriving while done is high is still ignored.
                    if (done) begin
                        busy <= 1'b0;
                    end else if (capture) begin
                        for (int i = 0; i < WORDS; i++) begin
                            buf_q[i] <= in_z_flat[i*R_W +: R_W];
                        end
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        data_out  <= cur_bit;
                        out_valid <= 1'b1;
                        word_last <= (bit_cnt == LAST_BIT);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (word_cnt == LAST_WORD) begin
                                word_cnt <= '0;
                                state    <= DONE;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                        word_last <= 1'b0;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    word_last <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_control.sv
// Purpose: self-checking bench for output_control (table of drain vectors + scoreboard).
// Latency: n/a (bench).
// Backpressure: exercises shift_en stalls, fixed and random.
module tb_output_control;

    localparam int N     = 2;
    localparam int R_W   = 16;
    localparam int WORDS = N * N;
`ifdef OUTPUT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BPW     = R_W + (PAR ? 1 : 0);
    localparam int EXP_LEN = WORDS * BPW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   capture = 1'b0;
    logic                   shift_en = 1'b0;
    logic [WORDS*R_W-1:0]   in_z_flat = '0;
    logic                   data_out, out_valid, word_last, busy, done;

    output_control #(.N(N), .R_W(R_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_z_flat (in_z_flat),
        .capture   (capture),
        .shift_en  (shift_en),
        .data_out  (data_out),
        .out_valid (out_valid),
        .word_last (word_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORDS*R_W-1:0] z;         // {w3, w2, w1, w0}
        int                   stall_at;  // stall after this bit index (-1: none)
        int                   stall_len;
        int                   recap_at;  // re-assert capture with zeros at this count (-1: none)
        bit                   rnd_stall;
        int                   exp_len;   // expected number of valid bits
        logic                 exp_first; // expected first serial bit
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_q[$];   // {bit, word_last}
    vec_t       vecs[5];
    int         vcnt, cyc;
    bit         saw_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference stream: LSB first per word, word 0 first, optional even-parity bit.
    task automatic push_expected(input logic [WORDS*R_W-1:0] z);
        for (int w = 0; w < WORDS; w++) begin
            logic [R_W-1:0] wd;
            wd = z[w*R_W +: R_W];
            for (int b = 0; b < R_W; b++) begin
                exp_q.push_back({wd[b], ((b == R_W - 1) && !PAR)});
            end
            if (PAR) exp_q.push_back({^wd, 1'b1});
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   c, n, first_vc, last_vc, done_cyc, stall_left;
        logic prev;
        logic [1:0] e;
        exp_q.delete();
        in_z_flat = v.z;
        capture   = 1'b1;
        shift_en  = 1'b1;          // capture wins; no bit shifted on this edge
        push_expected(v.z);
        @(posedge clk); #1;
        capture   = 1'b0;
        in_z_flat = ~v.z;          // must not affect the stream
        @(negedge clk);
        check({tag, "_cap_no_bit"}, out_valid, 0);
        check({tag, "_cap_busy"}, busy, 1);
        c = 0; n = 0; first_vc = -1; last_vc = -10; done_cyc = -1; stall_left = 0;
        prev = data_out;
        while (done_cyc < 0 && c < 2000) begin
            if (v.rnd_stall) shift_en = ($urandom_range(0, 2) != 0);
            else             shift_en = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            capture = (n == v.recap_at);
            if (capture) in_z_flat = '0;
            @(posedge clk); #1;
            capture = 1'b0;
            @(negedge clk);
            c++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_bit"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_data_b%0d", tag, n), data_out, e[1]);
                    check($sformatf("%s_last_b%0d", tag, n), word_last, e[0]);
                end
                if (n == 0) begin
                    check({tag, "_first_bit"}, data_out, v.exp_first);
                    first_vc = c;
                end
                n++;
                last_vc = c;
                if (n == v.stall_at + 1) stall_left = v.stall_len;
            end else if (n > 0) begin
                check({tag, "_hold_data"}, data_out, prev);
                check({tag, "_idle_last"}, word_last, 0);
            end
            prev = data_out;
            if (done) done_cyc = c;
        end
        check({tag, "_done_seen"}, (done_cyc >= 0), 1);
        if (done_cyc >= 0) begin
            check({tag, "_len"}, n, v.exp_len);
            check({tag, "_done_timing"}, done_cyc, last_vc + 1);
            check({tag, "_busy_at_done"}, busy, 1);
            check({tag, "_q_empty"}, exp_q.size(), 0);
            if (!v.rnd_stall)
                check({tag, "_gap_cycles"}, (last_vc - first_vc + 1) - n,
                      (v.stall_at >= 0) ? v.stall_len : 0);
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_busy_fall"}, busy, 0);
        end
    endtask

    initial begin
        logic [63:0] r;
        vecs[0] = '{{16'hFFFF, 16'hA5A5, 16'h8000, 16'h0001}, -1, 0, -1, 1'b0, EXP_LEN, 1'b1};
        vecs[1] = '{{16'hFFFF, 16'hA5A5, 16'h8000, 16'h0001}, 20, 3, -1, 1'b0, EXP_LEN, 1'b1};
        vecs[2] = '{{16'hFFFF, 16'hA5A5, 16'h8000, 16'h0001}, -1, 0, 10, 1'b0, EXP_LEN, 1'b1};
        vecs[3] = '{{16'h0000, 16'h0000, 16'h0001, 16'h0003}, -1, 0, -1, 1'b0, EXP_LEN, 1'b1};
        r = {$urandom(), $urandom()};
        vecs[4] = '{r, -1, 0, -1, 1'b1, EXP_LEN, r[0]};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_word_last", word_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;

        // Idle with shift_en toggling and no capture
        for (int i = 0; i < 10; i++) begin
            shift_en = i[0];
            @(posedge clk); #1;
            @(negedge clk);
            check("idle_valid", out_valid, 0);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_data", data_out, 0);
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted when bit 30 is due
        exp_q.delete();
        in_z_flat = vecs[0].z;
        capture   = 1'b1;
        shift_en  = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        vcnt = 0; cyc = 0;
        while (vcnt < 30 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (out_valid) vcnt++;
        end
        check("mid_rst_reached_bit30", vcnt, 30);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done", done, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || out_valid) saw_done = 1'b1;
        end
        check("mid_rst_no_done", saw_done, 0);
        run_vec(vecs[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
